// File: rtl/dp_mem_pkg.sv
// Shared widths and encodings for the dp_mem copy/fill engine.
// Mode and FSM state enums live here so the bench can name them too.
package dp_mem_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic {
        MODE_COPY = 1'b0,
        MODE_FILL = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/dp_mem_lat_pipe.sv
// Read-latency shift pipe: a valid bit plus the write index per stage.
// empty means nothing sits behind the tail, so the pipe clears next edge.
module dp_mem_lat_pipe #(
    parameter int IDX_W  = 4,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic             empty
);

    logic [STAGES-1:0] vld;
    logic [IDX_W-1:0]  idx [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < STAGES; i++) idx[i] <= '0;
        end else begin
            vld[0] <= in_valid;
            idx[0] <= in_idx;
            for (int i = 1; i < STAGES; i++) begin
                vld[i] <= vld[i-1];
                idx[i] <= idx[i-1];
            end
        end
    end

    assign out_valid = vld[STAGES-1];
    assign out_idx   = idx[STAGES-1];

    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < STAGES - 1; i++) begin
            if (vld[i]) empty = 1'b0;
        end
    end

endmodule

// File: rtl/dp_mem_copy_engine.sv
// Block copy / fill initiator for dp_mem: registered reads, writes
// driven from the latency pipe tail (copy) or straight from the FSM (fill).
module dp_mem_copy_engine #(
    parameter int DATA_W = dp_mem_pkg::DATA_W,
    parameter int ADDR_W = dp_mem_pkg::ADDR_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] pattern,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              enb,
    output logic              rd,
    output logic [ADDR_W-1:0] r_addr,
    input  logic [DATA_W-1:0] r_data,
    output logic              wr,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_data
);

    import dp_mem_pkg::*;

    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(1 << ADDR_W);

    state_e            state;
    mode_e             mode_q;
    logic [ADDR_W:0]   src_q, dst_q, len_q, cnt;
    logic [ADDR_W-1:0] rd_idx;
    logic [DATA_W-1:0] pat_q;
    logic              err_q;

    logic [ADDR_W:0]   src_x, dst_x, src_end, dst_end;
    logic              is_copy, reject;

    logic              tail_valid, pipe_empty;
    logic [ADDR_W-1:0] tail_idx;

    // One extra address bit keeps base+len exact, so ranges never wrap.
    always_comb begin
        src_x   = {1'b0, src_addr};
        dst_x   = {1'b0, dst_addr};
        src_end = src_x + len;
        dst_end = dst_x + len;
        is_copy = (mode_e'(mode) == MODE_COPY);
        reject  = (dst_end > DEPTH_V)
                || (is_copy && (src_end > DEPTH_V))
                || (is_copy && (src_x < dst_x) && (dst_x < src_end));
    end

    dp_mem_lat_pipe #(
        .IDX_W  (ADDR_W),
        .STAGES (RD_LAT)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd),
        .in_idx    (rd_idx),
        .out_valid (tail_valid),
        .out_idx   (tail_idx),
        .empty     (pipe_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            mode_q <= MODE_COPY;
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            cnt    <= '0;
            pat_q  <= '0;
            rd     <= 1'b0;
            r_addr <= '0;
            rd_idx <= '0;
            err_q  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q <= mode_e'(mode);
                        src_q  <= src_x;
                        dst_q  <= dst_x;
                        len_q  <= len;
                        pat_q  <= pattern;
                        if (reject) begin
                            err_q <= 1'b1;
                            state <= ST_DONE;
                        end else if (len == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_RUN;
                            if (is_copy) begin
                                rd     <= 1'b1;
                                r_addr <= src_addr;
                                rd_idx <= '0;
                                cnt    <= (ADDR_W+1)'(1);
                            end else begin
                                cnt <= '0;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (mode_q == MODE_COPY) begin
                        if (cnt == len_q) begin
                            rd    <= 1'b0;
                            state <= ST_DRAIN;
                        end else begin
                            rd     <= 1'b1;
                            r_addr <= ADDR_W'(src_q + cnt);
                            rd_idx <= ADDR_W'(cnt);
                            cnt    <= cnt + 1'b1;
                        end
                    end else if (cnt + 1'b1 == len_q) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (pipe_empty) state <= ST_DONE;
                end
                ST_DONE: begin
                    err_q <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        wr     = 1'b0;
        w_addr = '0;
        w_data = '0;
        if (state == ST_RUN && mode_q == MODE_FILL) begin
            wr     = 1'b1;
            w_addr = ADDR_W'(dst_q + cnt);
            w_data = pat_q;
        end else if (tail_valid) begin
            wr     = 1'b1;
            w_addr = ADDR_W'(dst_q + {1'b0, tail_idx});
            w_data = r_data;
        end
    end

    assign enb  = rd | wr;
    assign busy = (state == ST_RUN) || (state == ST_DRAIN);
    assign done = (state == ST_DONE);
    assign err  = err_q;

endmodule
